// File: rtl/sram_size_probe.sv
// sram_size_probe: boot-time SRAM capacity detector.
// Runs a fixed write/read-back aliasing test through the SRAM arbiter and
// reports 512 KB (00), 1 MB (01) or 2 MB (10) with a one-cycle done strobe.
module sram_size_probe #(
    parameter int TIMEOUT = 255   // ack wait limit per access, 1..255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [20:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    input  logic [7:0]  i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_memsize,
    output logic        o_error
);

    typedef enum logic [3:0] {
        S_IDLE, S_W0, S_W1, S_R1, S_R0A, S_W2, S_R2, S_R0B, S_GAP, S_FIN
    } state_t;

    localparam logic [1:0] SZ_512K = 2'b00;
    localparam logic [1:0] SZ_1M   = 2'b01;
    localparam logic [1:0] SZ_2M   = 2'b10;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      r_after;      // where GAP goes once the request has dropped
    logic [1:0]  r_res_size;   // size decided by a read, applied when FIN is entered
    logic [7:0]  r_cnt;        // ack wait counter for the current access
    logic [1:0]  r_memsize;
    logic        r_error;

    state_t      w_next;
    state_t      w_after;
    logic [1:0]  w_res_size;
    logic [1:0]  w_fin_size;
    logic        w_fin_err;
    logic        w_is_acc;
    logic        w_ack;
    logic        w_tmo;

    // Access states are the only ones that hold mem_req high.
    always_comb begin
        w_is_acc = 1'b0;
        case (r_state)
            S_W0, S_W1, S_R1, S_R0A, S_W2, S_R2, S_R0B: w_is_acc = 1'b1;
            default:                                    w_is_acc = 1'b0;
        endcase
    end

    // An ack is honoured only while a request is outstanding; an ack on the
    // last allowed wait cycle wins over the timeout.
    assign w_ack = w_is_acc & i_mem_ack;
    assign w_tmo = w_is_acc & ~i_mem_ack & (r_cnt == TMO_LAST);

    // State register plus the decision registers that travel with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_after    <= S_IDLE;
            r_res_size <= SZ_512K;
        end else begin
            r_state    <= w_next;
            r_after    <= w_after;
            r_res_size <= w_res_size;
        end
    end

    // Next-state logic: every ack goes through GAP so mem_req drops for a cycle.
    always_comb begin
        w_next     = r_state;
        w_after    = r_after;
        w_res_size = r_res_size;
        w_fin_size = r_res_size;
        w_fin_err  = 1'b0;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_W0;
            S_W0: if (w_ack) begin
                w_next  = S_GAP;
                w_after = S_W1;
            end
            S_W1: if (w_ack) begin
                w_next  = S_GAP;
                w_after = S_R1;
            end
            S_R1: if (w_ack) begin
                w_next = S_GAP;
                if (i_mem_rdata != 8'hA5) begin
                    w_after    = S_FIN;
                    w_res_size = SZ_512K;
                end else begin
                    w_after = S_R0A;
                end
            end
            S_R0A: if (w_ack) begin
                w_next = S_GAP;
                if (i_mem_rdata != 8'h00) begin
                    w_after    = S_FIN;
                    w_res_size = SZ_512K;
                end else begin
                    w_after = S_W2;
                end
            end
            S_W2: if (w_ack) begin
                w_next  = S_GAP;
                w_after = S_R2;
            end
            S_R2: if (w_ack) begin
                w_next = S_GAP;
                if (i_mem_rdata != 8'h5A) begin
                    w_after    = S_FIN;
                    w_res_size = SZ_1M;
                end else begin
                    w_after = S_R0B;
                end
            end
            S_R0B: if (w_ack) begin
                w_next     = S_GAP;
                w_after    = S_FIN;
                w_res_size = (i_mem_rdata != 8'h00) ? SZ_1M : SZ_2M;
            end
            S_GAP:   w_next = r_after;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Timeout aborts straight to FIN; once W2 has completed 1 MB is proven.
        if (w_tmo) begin
            w_next     = S_FIN;
            w_fin_err  = 1'b1;
            w_fin_size = (r_state == S_R2 || r_state == S_R0B) ? SZ_1M : SZ_512K;
        end
    end

    // Ack wait counter: cleared outside accesses, counts unacked request cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst)                      r_cnt <= 8'd0;
        else if (w_is_acc && !i_mem_ack) r_cnt <= r_cnt + 8'd1;
        else                            r_cnt <= 8'd0;
    end

    // Result registers load on entry to FIN so they are valid with done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_memsize <= SZ_512K;
            r_error   <= 1'b0;
        end else if (w_next == S_FIN) begin
            r_memsize <= w_fin_size;
            r_error   <= w_fin_err;
        end
    end

    // Output decode from the current state.
    always_comb begin
        o_mem_req   = w_is_acc;
        o_mem_we    = 1'b0;
        o_mem_addr  = 21'h000000;
        o_mem_wdata = 8'h00;
        o_busy      = (r_state != S_IDLE) && (r_state != S_FIN);
        o_done      = (r_state == S_FIN);
        case (r_state)
            S_W0: begin
                o_mem_we = 1'b1;
            end
            S_W1: begin
                o_mem_we    = 1'b1;
                o_mem_addr  = 21'h080000;
                o_mem_wdata = 8'hA5;
            end
            S_R1:  o_mem_addr = 21'h080000;
            S_W2: begin
                o_mem_we    = 1'b1;
                o_mem_addr  = 21'h100000;
                o_mem_wdata = 8'h5A;
            end
            S_R2:  o_mem_addr = 21'h100000;
            default: ;
        endcase
    end

    assign o_memsize = r_memsize;
    assign o_error   = r_error;

endmodule

// File: tb/tb_sram_size_probe.sv
// Bench for sram_size_probe: an SRAM/arbiter model with selectable aliasing
// and random ack latency, plus a timeline model of every output per cycle.
module tb_sram_size_probe;
    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst, start, mem_req, mem_we, mem_ack;
    logic [20:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        busy, done, error;
    logic [1:0]  memsize;

    always #5 clk = ~clk;

    sram_size_probe #(.TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
        .o_busy(busy), .o_done(done), .o_memsize(memsize), .o_error(error)
    );

    // probe access list, in the order the detector must issue it
    logic [20:0] A_ADDR [7] = '{21'h000000, 21'h080000, 21'h080000, 21'h000000,
                                21'h100000, 21'h100000, 21'h000000};
    logic        A_WE   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0]  A_WD   [7] = '{8'h00, 8'hA5, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00};
    logic [7:0]  A_RD   [7] = '{8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h5A, 8'h00};
    logic [1:0]  A_FAIL [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};

    int errs = 0, checks = 0, cyc = 0;
    logic [7:0] sram [int];
    logic [7:0] mm   [int];
    logic [7:0] seed;
    logic [1:0] exp_ms = 2'b00;
    logic       exp_er = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [20:0] amask(input int mode);
        case (mode)
            1:       return 21'h0FFFFF;
            2:       return 21'h07FFFF;
            default: return 21'h1FFFFF;
        endcase
    endfunction

    function automatic logic [7:0] bg(input int a);
        return 8'(a * 37) ^ seed;
    endfunction

    // mode: 0 = 2 MB, 1 = 1 MB, 2 = 512 KB, 3 = broken part reading 0xFF.
    // tmo_at: access index never acked (-1 none); bnd_at: access acked on the
    // last legal wait cycle; noise: spurious start pulses and idle acks.
    task automatic run_probe(input int mode, input int tmo_at, input int bnd_at,
                             input int maxd, input bit noise, output int dcyc);
        int n, d[7], ts[7], te[7], t, done_t, a, k2;
        logic [1:0] sz;
        logic       er, inreq, ackq;
        logic [7:0] rv;
        logic [20:0] msk;
        msk = amask(mode);
        seed = 8'($urandom);
        sram.delete();
        mm.delete();
        // abstract model: walk the access list against an ideal aliased memory
        n = 0; sz = 2'd2; er = 1'b0;
        for (int k = 0; k < 7; k++) begin
            n = k + 1;
            a = int'(A_ADDR[k] & msk);
            if (A_WE[k]) mm[a] = A_WD[k];
            else begin
                rv = (mode == 3) ? 8'hFF : (mm.exists(a) ? mm[a] : bg(a));
                if (rv != A_RD[k]) begin sz = A_FAIL[k]; break; end
            end
        end
        if (tmo_at >= 0 && tmo_at < n) begin
            n = tmo_at + 1; er = 1'b1; sz = (tmo_at >= 5) ? 2'd1 : 2'd0;
        end
        // timeline: req at t, ack at t+d, low at t+d+1, next req at t+d+2
        t = 1; done_t = 0;
        for (int k = 0; k < n; k++) begin
            d[k] = (k == bnd_at) ? TMO - 1 : int'($urandom_range(1, maxd));
            ts[k] = t;
            if (er && k == n - 1) begin te[k] = t + TMO - 1; done_t = t + TMO; end
            else begin te[k] = t + d[k]; t = te[k] + 2; done_t = te[k] + 2; end
        end
        dcyc = -1;
        for (int c = 0; c <= done_t + 3; c++) begin
            @(negedge clk);
            cyc = c;
            inreq = 1'b0; ackq = 1'b0; k2 = 0;
            for (int k = 0; k < n; k++)
                if (c >= ts[k] && c <= te[k]) begin
                    inreq = 1'b1; k2 = k;
                    ackq = (c == te[k]) && !(er && k == n - 1);
                end
            if (done === 1'b1 && dcyc < 0) dcyc = c;
            chk("mem_req", mem_req, inreq);
            chk("busy", busy, (c >= 1 && c < done_t));
            chk("done", done, (c == done_t));
            chk("memsize", memsize, (c >= done_t) ? sz : exp_ms);
            chk("error", error, (c >= done_t) ? er : exp_er);
            if (inreq) begin
                chk("mem_addr", mem_addr, A_ADDR[k2]);
                chk("mem_we", mem_we, A_WE[k2]);
                chk("mem_wdata", mem_wdata, A_WD[k2]);
            end
            start = (c == 0) || (noise && c == done_t) ||
                    (noise && c > 0 && c < done_t && $urandom_range(0, 3) == 0);
            mem_ack = ackq || (noise && !inreq && c > 0 && c < done_t &&
                               $urandom_range(0, 2) == 0);
            a = int'(mem_addr & msk);
            mem_rdata = 8'($urandom);
            if (mem_ack && mem_req) begin
                if (mem_we) sram[a] = mem_wdata;
                else mem_rdata = (mode == 3) ? 8'hFF : (sram.exists(a) ? sram[a] : bg(a));
            end
        end
        start = 1'b0; mem_ack = 1'b0;
        exp_ms = sz; exp_er = er;
    endtask

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_req", mem_req, 0);   chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
        chk("rst_memsize", memsize, 0); chk("rst_error", error, 0);
        rst = 1'b0;

        // directed paths with one-cycle ack
        run_probe(0, -1, -1, 1, 1'b0, dc);
        chk("done_cyc_2M", dc, 22);   chk("size_2M", memsize, 2'b10);
        run_probe(1, -1, -1, 1, 1'b0, dc);
        chk("done_cyc_1M", dc, 22);   chk("size_1M", memsize, 2'b01);
        run_probe(2, -1, -1, 1, 1'b0, dc);
        chk("done_cyc_512K", dc, 13); chk("size_512K", memsize, 2'b00);
        run_probe(3, -1, -1, 1, 1'b0, dc);
        chk("done_cyc_short", dc, 10);
        // R2 never acked
        run_probe(0, 5, -1, 1, 1'b0, dc);
        chk("done_cyc_tmo", dc, 271); chk("size_tmo", memsize, 2'b01);
        chk("err_tmo", error, 1);
        // start pulses while busy and in the done cycle, idle acks
        run_probe(0, -1, -1, 1, 1'b1, dc);
        chk("done_cyc_noise", dc, 22); chk("err_clear", error, 0);
        // ack on the last legal wait cycle completes normally
        run_probe(0, -1, 2, 2, 1'b0, dc);
        chk("size_bnd", memsize, 2'b10); chk("err_bnd", error, 0);
        // timeout on the very first access
        run_probe(0, 0, -1, 1, 1'b0, dc);
        chk("done_cyc_tmo0", dc, 256); chk("size_tmo0", memsize, 2'b00);

        // reset while W1 waits for ack, then a late ack
        run_probe(0, -1, -1, 1, 1'b0, dc);
        @(negedge clk); cyc = 0; start = 1'b1;
        @(negedge clk); cyc = 1; start = 1'b0; mem_ack = 1'b1;
        chk("rt_w0_req", mem_req, 1);
        @(negedge clk); cyc = 2; mem_ack = 1'b0;
        @(negedge clk); cyc = 3;
        chk("rt_w1_req", mem_req, 1); chk("rt_w1_addr", mem_addr, 21'h080000);
        rst = 1'b1;
        @(negedge clk); cyc = 4; rst = 1'b0; mem_ack = 1'b1;
        chk("rt_req", mem_req, 0); chk("rt_busy", busy, 0);
        chk("rt_memsize", memsize, 0); chk("rt_error", error, 0);
        chk("rt_done", done, 0);
        @(negedge clk); cyc = 5; mem_ack = 1'b0;
        chk("rt_late_req", mem_req, 0); chk("rt_late_busy", busy, 0);
        exp_ms = 2'b00; exp_er = 1'b0;
        run_probe(0, -1, -1, 1, 1'b0, dc);
        chk("rt_clean_done", dc, 22);

        // randomized probes
        for (int i = 0; i < 16; i++) begin
            int md, ta;
            md = int'($urandom_range(0, 3));
            ta = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_probe(md, ta, -1, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), dc);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/sram_size_probe.md
# sram_size_probe

Boot-time SRAM capacity detector on the memory-side of the board capabilities register. On `start` it runs a fixed write/read-back aliasing test through the SRAM arbiter and reports 512 KB, 1 MB or 2 MB. The boot firmware reads the result and writes it into the memory-report field of the capabilities register, which is writable only in boot mode. It drives `memsize` and a one-cycle `done` strobe; `memsize` can also feed the register's data input directly.

## Interface
- `TIMEOUT`, default 255: arbiter cycles to wait for `mem_ack` on one access before aborting (1..255).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a probe; sampled only in IDLE.
- `mem_req`  out  1  access request to SRAM arbiter; held until `mem_ack`.
- `mem_we`  out  1  1 = write, 0 = read; stable while `mem_req`.
- `mem_addr`  out  21  byte address; stable while `mem_req`.
- `mem_wdata`  out  8  write data; stable while `mem_req`.
- `mem_rdata`  in  8  read data; valid in the `mem_ack` cycle.
- `mem_ack`  in  1  one-cycle completion strobe from arbiter.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  one-cycle strobe; `memsize` and `error` are valid from this cycle.
- `memsize`  out  2  00 = 512 KB, 01 = 1 MB, 10 = 2 MB; 11 is never produced.
- `error`  out  1  last probe aborted on timeout.

## Operation
- Each access state raises `mem_req` with a fixed addr/we/wdata and waits for `mem_ack`.
- On ack the FSM drops `mem_req` in the next cycle and advances. `mem_req` is never high for two consecutive accesses without one low cycle between them.
- State sequence:
  - IDLE: on `start` -> W0.
  - W0: write 0x00 @ 0x000000 -> W1.
  - W1: write 0xA5 @ 0x080000 -> R1.
  - R1: read @ 0x080000; if != 0xA5 -> FIN with size 00; else -> R0A.
  - R0A: read @ 0x000000; if != 0x00 (alias) -> FIN with size 00; else -> W2.
  - W2: write 0x5A @ 0x100000 -> R2.
  - R2: read @ 0x100000; if != 0x5A -> FIN with size 01; else -> R0B.
  - R0B: read @ 0x000000; if != 0x00 -> FIN with size 01; else -> FIN with size 10.
  - FIN: `done` = 1, `busy` = 0, register `memsize`/`error` -> IDLE.
- Timeout: an 8-bit counter clears when each access starts and increments every cycle `mem_req` is high without `mem_ack`.
  - When it reaches `TIMEOUT`: drop `mem_req`, go to FIN with `error` = 1. `memsize` = 00 if the timeout is before W2 completes, else 01.
- `memsize` and `error` hold their values from FIN until the next FIN. They do not change while a new probe runs.
- `start` while busy or in FIN is ignored. `start` in the same cycle as `done` is ignored.
- SRAM contents at the probed addresses are destroyed. The probe runs only before the boot ROM uses SRAM.

## Timing
- Reset values: `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0, `done` 0, `memsize` 00, `error` 0; state IDLE; timeout counter 0.
- `rst` mid-probe: next cycle the FSM is in IDLE with all outputs at reset values. An outstanding `mem_req` drops immediately. A late `mem_ack` is ignored.
- `start` at cycle 0 -> `busy` and `mem_req` (W0) high at cycle 1.
- `mem_ack` at cycle n -> `mem_req` low at n+1, next request high at n+2.
- Decision paths, with ack one cycle after each request:
  - Shortest (fail at R1): `done` at cycle 10.
  - Full 2 MB path (7 accesses): `done` at cycle 22.
  - Each extra ack wait adds one cycle.
- `mem_rdata` is sampled only in the `mem_ack` cycle.
- `mem_ack` with `mem_req` low is ignored.
- `mem_ack` in the same cycle as the timeout threshold counts as ack: the access completes and there is no error.

## Test plan
- 2 MB model (no aliasing), ack after 1 cycle: `start` -> exactly 7 accesses in the listed order, `done` at cycle 22, `memsize` = 10, `error` = 0.
- 1 MB model (addr bit 20 ignored, so 0x100000 aliases 0x000000) -> R0B reads 0x5A, `memsize` = 01 after 7 accesses.
- 512 KB model (bits 20:19 ignored) -> R0A reads 0xA5, `memsize` = 00 after 4 accesses, W2 never issued.
- Arbiter never acks R2, `TIMEOUT` = 255 -> `mem_req` drops after 255 wait cycles, `done` strobes, `memsize` = 01, `error` = 1.
- `rst` asserted while W1 awaits ack -> next cycle `mem_req` = 0, `busy` = 0, `memsize` = 00. A following `start` runs a clean full probe.
- `start` pulsed during busy and in the `done` cycle -> no second probe starts; `done` strobes exactly once.
